// File: rtl/mqtt_demo_pkg.sv
// Shared types and constants for the MQTT publish scheduler.
// Holds the FSM state encoding, counter widths and the channel-index width helper.
package mqtt_demo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } pub_state_t;

    localparam int SEQ_W  = 16;
    localparam int OVF_W  = 8;
    localparam int MAX_CH = 8;

    // Index width for n items; never returns 0 so ports stay legal for n=1.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef logic [$clog2(MAX_CH)-1:0] ch_idx_t;

endpackage

// File: rtl/mqtt_rr_arbiter.sv
// Round-robin pick among eligible channels, searching upward from rr_ptr with wrap.
// Purely combinational: zero latency, no backpressure of its own.
module mqtt_rr_arbiter
    import mqtt_demo_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int CH_W = ch_w(N_CH)
) (
    input  logic [N_CH-1:0] eligible,
    input  logic [CH_W-1:0] rr_ptr,
    output logic            gnt_valid,
    output logic [CH_W-1:0] gnt_idx
);

    always_comb begin
        int idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(rr_ptr) + i) % N_CH;
            if (!gnt_valid && eligible[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx[CH_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mqtt_pub_scheduler.sv
// Round-robin publish scheduler with per-channel ms holdoff; grant appears 1 cycle after pending is seen in IDLE.
// Descriptor is held stable until m_ready; one outstanding at a time, so grants are at least 2 cycles apart.
module mqtt_pub_scheduler
    import mqtt_demo_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int TICK_DIV = 100000,
    parameter int IVL_W    = 16,
    localparam int CH_W    = ch_w(N_CH),
    localparam int TCW     = ch_w(TICK_DIV)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [N_CH-1:0]       req,
    input  logic [N_CH*IVL_W-1:0] min_ivl,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CH_W-1:0]       m_ch,
    output logic [SEQ_W-1:0]      m_seq,
    output logic                  irq,
    output logic                  busy,
    output logic [OVF_W-1:0]      ovf_cnt,
    output logic [N_CH-1:0]       pending
);

    pub_state_t      state_q, state_d;
    logic [TCW-1:0]  tick_cnt;
    logic            tick;
    logic [CH_W-1:0] rr_ptr;
    logic [N_CH-1:0] eligible;
    logic [N_CH-1:0] hold_zero;
    logic [N_CH-1:0] clr;
    logic [N_CH-1:0] drop;
    logic [N_CH-1:0] pending_d;
    logic            gnt_valid;
    logic [CH_W-1:0] gnt_idx;
    logic            grant_load;
    logic            hs;
    logic [3:0]      drop_n;
    logic [OVF_W:0]  ovf_sum;

    assign tick    = (tick_cnt == TCW'(TICK_DIV - 1));
    assign m_valid = (state_q == SEND);
    assign busy    = (state_q != IDLE);

    always_comb begin
        drop_n = '0;
        for (int k = 0; k < N_CH; k++) begin
            clr[k]       = hs && (m_ch == CH_W'(k));
            drop[k]      = req[k] && pending[k] && !clr[k];
            pending_d[k] = req[k] || (pending[k] && !clr[k]);
            eligible[k]  = pending[k] && hold_zero[k] && enable;
            drop_n       = drop_n + {3'b000, drop[k]};
        end
        ovf_sum = {1'b0, ovf_cnt} + (OVF_W+1)'(drop_n);
    end

    // A tick landing on the load cycle is counted, so eligibility falls within (n-1, n] ms.
    for (genvar k = 0; k < N_CH; k++) begin : g_hold
        logic [IVL_W-1:0] hold_q;
        logic [IVL_W-1:0] ivl;
        assign ivl          = min_ivl[k*IVL_W +: IVL_W];
        assign hold_zero[k] = (hold_q == '0);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hold_q <= '0;
            end else if (clr[k]) begin
                hold_q <= (tick && ivl != '0) ? ivl - 1'b1 : ivl;
            end else if (tick && hold_q != '0) begin
                hold_q <= hold_q - 1'b1;
            end
        end
    end

    mqtt_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_d    = state_q;
        grant_load = 1'b0;
        hs         = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d    = SEND;
                    grant_load = 1'b1;
                end
            end
            SEND: begin
                if (m_ready) begin
                    state_d = IDLE;
                    hs      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tick_cnt <= '0;
            rr_ptr   <= '0;
            m_ch     <= '0;
            m_seq    <= '0;
            irq      <= 1'b0;
            ovf_cnt  <= '0;
            pending  <= '0;
        end else begin
            state_q  <= state_d;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            irq      <= hs;
            pending  <= pending_d;
            ovf_cnt  <= ovf_sum[OVF_W] ? {OVF_W{1'b1}} : ovf_sum[OVF_W-1:0];
            if (grant_load) begin
                m_ch <= gnt_idx;
            end
            if (hs) begin
                m_seq  <= m_seq + 1'b1;
                rr_ptr <= (m_ch == CH_W'(N_CH - 1)) ? '0 : m_ch + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mqtt_pub_scheduler.sv
// Directed bench for mqtt_pub_scheduler: vector table for grant/round-robin/overflow,
// hand sequences for stall, enable drop, holdoff, saturation and mid-transfer reset.
module tb_mqtt_pub_scheduler;

    localparam int N_CH  = 4;
    localparam int IVL_W = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  enable;
    logic [N_CH-1:0]       req;
    logic [N_CH*IVL_W-1:0] min_ivl;
    logic                  m_valid;
    logic                  m_ready;
    logic [1:0]            m_ch;
    logic [15:0]           m_seq;
    logic                  irq;
    logic                  busy;
    logic [7:0]            ovf_cnt;
    logic [N_CH-1:0]       pending;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mqtt_pub_scheduler #(.N_CH(N_CH), .TICK_DIV(10), .IVL_W(IVL_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .req     (req),
        .min_ivl (min_ivl),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_ch    (m_ch),
        .m_seq   (m_seq),
        .irq     (irq),
        .busy    (busy),
        .ovf_cnt (ovf_cnt),
        .pending (pending)
    );

    typedef struct {
        logic [3:0]  req;
        logic        en;
        logic        rdy;
        logic        mv;
        logic [1:0]  ch;
        logic [15:0] seq;
        logic        irq;
        logic [3:0]  pend;
        logic [7:0]  ovf;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        enable  = 1'b1;
        m_ready = 1'b1;
        min_ivl = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic add(input logic [3:0] r, input logic en, input logic rdy, input logic mv,
                       input logic [1:0] ch, input logic [15:0] seq, input logic ir,
                       input logic [3:0] pend, input logic [7:0] ovf);
        vec_t v;
        v.req = r; v.en = en; v.rdy = rdy; v.mv = mv; v.ch = ch;
        v.seq = seq; v.irq = ir; v.pend = pend; v.ovf = ovf;
        tv.push_back(v);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mv"},   int'(m_valid), 0);
        chk({tag, "_ch"},   int'(m_ch),    0);
        chk({tag, "_seq"},  int'(m_seq),   0);
        chk({tag, "_irq"},  int'(irq),     0);
        chk({tag, "_busy"}, int'(busy),    0);
        chk({tag, "_ovf"},  int'(ovf_cnt), 0);
        chk({tag, "_pend"}, int'(pending), 0);
    endtask

    initial begin
        int seen;
        int hcyc;
        int delta;
        logic [1:0]  ch0;
        logic [15:0] seq0;

        // req, en, rdy | mv, ch, seq, irq, pend, ovf  (outputs after the edge)
        add(4'h0, 1, 1, 0, 0, 0, 0, 4'h0, 0);
        add(4'hF, 1, 1, 0, 0, 0, 0, 4'hF, 0);
        add(4'h0, 1, 1, 1, 0, 0, 0, 4'hF, 0);
        add(4'h0, 1, 1, 0, 0, 1, 1, 4'hE, 0);
        add(4'h0, 1, 1, 1, 1, 1, 0, 4'hE, 0);
        add(4'h0, 1, 1, 0, 1, 2, 1, 4'hC, 0);
        add(4'h0, 1, 1, 1, 2, 2, 0, 4'hC, 0);
        add(4'h0, 1, 1, 0, 2, 3, 1, 4'h8, 0);
        add(4'h0, 1, 1, 1, 3, 3, 0, 4'h8, 0);
        add(4'h0, 1, 1, 0, 3, 4, 1, 4'h0, 0);
        add(4'h0, 1, 1, 0, 3, 4, 0, 4'h0, 0);
        add(4'h4, 1, 1, 0, 3, 4, 0, 4'h4, 0);
        add(4'h0, 1, 1, 1, 2, 4, 0, 4'h4, 0);
        add(4'h0, 1, 1, 0, 2, 5, 1, 4'h0, 0);
        add(4'h2, 1, 1, 0, 2, 5, 0, 4'h2, 0);
        add(4'h0, 1, 1, 1, 1, 5, 0, 4'h2, 0);
        add(4'h2, 1, 1, 0, 1, 6, 1, 4'h2, 0);
        add(4'h0, 1, 1, 1, 1, 6, 0, 4'h2, 0);
        add(4'h0, 1, 1, 0, 1, 7, 1, 4'h0, 0);
        add(4'h1, 0, 1, 0, 1, 7, 0, 4'h1, 0);
        add(4'h1, 0, 1, 0, 1, 7, 0, 4'h1, 1);
        add(4'h0, 0, 1, 0, 1, 7, 0, 4'h1, 1);
        add(4'h0, 1, 1, 1, 0, 7, 0, 4'h1, 1);
        add(4'h0, 1, 1, 0, 0, 8, 1, 4'h0, 1);

        do_reset();
        chk_reset_vals("rst");

        foreach (tv[i]) begin
            req     = tv[i].req;
            enable  = tv[i].en;
            m_ready = tv[i].rdy;
            step();
            chk($sformatf("v%0d_mv", i),   int'(m_valid), int'(tv[i].mv));
            chk($sformatf("v%0d_busy", i), int'(busy),    int'(tv[i].mv));
            chk($sformatf("v%0d_ch", i),   int'(m_ch),    int'(tv[i].ch));
            chk($sformatf("v%0d_seq", i),  int'(m_seq),   int'(tv[i].seq));
            chk($sformatf("v%0d_irq", i),  int'(irq),     int'(tv[i].irq));
            chk($sformatf("v%0d_pend", i), int'(pending), int'(tv[i].pend));
            chk($sformatf("v%0d_ovf", i),  int'(ovf_cnt), int'(tv[i].ovf));
        end
        req = '0;

        // Stall for 20 cycles, drop enable midway with a new request pending.
        do_reset();
        m_ready = 1'b0;
        req = 4'h8;
        step();
        req = '0;
        step();
        chk("bp_mv_start", int'(m_valid), 1);
        chk("bp_ch_start", int'(m_ch), 3);
        ch0  = m_ch;
        seq0 = m_seq;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                enable = 1'b0;
                req    = 4'h1;
            end else begin
                req = '0;
            end
            step();
            chk($sformatf("bp%0d_mv", i),  int'(m_valid), 1);
            chk($sformatf("bp%0d_ch", i),  int'(m_ch),    int'(ch0));
            chk($sformatf("bp%0d_seq", i), int'(m_seq),   int'(seq0));
        end
        req     = '0;
        m_ready = 1'b1;
        step();
        chk("bp_irq", int'(irq), 1);
        chk("bp_mv_end", int'(m_valid), 0);
        chk("bp_seq_end", int'(m_seq), 1);
        chk("bp_pend", int'(pending), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("dis%0d_mv", i), int'(m_valid), 0);
        end

        // Drops while disabled, then saturation.
        do_reset();
        enable = 1'b0;
        req = 4'h1;
        step();
        chk("ovf_first", int'(ovf_cnt), 0);
        step();
        req = '0;
        chk("ovf_one", int'(ovf_cnt), 1);
        req = 4'h1;
        for (int i = 0; i < 300; i++) step();
        req = '0;
        step();
        chk("ovf_sat", int'(ovf_cnt), 255);
        chk("ovf_mv", int'(m_valid), 0);

        // Reset while a descriptor is stalled.
        do_reset();
        m_ready = 1'b0;
        req = 4'h4;
        step();
        req = '0;
        step();
        chk("rsend_mv", int'(m_valid), 1);
        rst_n = 1'b0;
        step();
        chk_reset_vals("rsend");
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rsend%0d_irq", i), int'(irq), 0);
        end

        // Holdoff of 3 ms on channel 1 (10-cycle tick).
        do_reset();
        min_ivl[1*IVL_W +: IVL_W] = 16'd3;
        req = 4'h2;
        step();
        req = '0;
        step();
        chk("ho_mv1", int'(m_valid), 1);
        chk("ho_ch1", int'(m_ch), 1);
        step();
        hcyc = cyc;
        chk("ho_irq1", int'(irq), 1);
        req = 4'h2;
        step();
        req = '0;
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            if (m_valid) seen = 1;
            else step();
        end
        delta = cyc - hcyc;
        chk("ho_seen", seen, 1);
        chk("ho_not_early", int'(delta >= 20), 1);
        chk("ho_not_late", int'(delta <= 30), 1);
        chk("ho_ch2", int'(m_ch), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mqtt_pub_scheduler.md
# mqtt_pub_scheduler

Schedules MQTT publish requests from up to `N_CH` PL-side sources onto the single descriptor path read by the PS7 MQTT client. Uses round-robin arbitration and enforces a per-channel minimum publish interval in millisecond ticks. Each grant carries a sequence number and raises a one-cycle interrupt to the PS. Sits in the PL between the sensor/event logic and the PS7 block-design wrapper, clocked from the PS fabric clock.

## Interface
- `N_CH`, 4: number of requesting channels (2..8)
- `TICK_DIV`, 100000: `clk` cycles per 1 ms tick (≥2)
- `IVL_W`, 16: width of each interval field, in ms
- `clk` in 1: fabric clock; all logic is rising-edge
- `rst_n` in 1: reset, synchronous, active-low
- `enable` in 1: when 0, no new grants are made
- `req` in N_CH: one-cycle request pulse per channel
- `min_ivl` in N_CH*IVL_W: per-channel minimum interval in ms; channel k occupies bits [k*IVL_W +: IVL_W]
- `m_valid` out 1: descriptor valid
- `m_ready` in 1: descriptor accepted by the PS side
- `m_ch` out clog2(N_CH): granted channel
- `m_seq` out 16: global publish sequence number
- `irq` out 1: one-cycle pulse per completed handshake
- `busy` out 1: high when state ≠ IDLE
- `ovf_cnt` out 8: dropped-request count, saturating
- `pending` out N_CH: per-channel pending flags, for status readback

## Operation
- The tick counter runs freely from 0 to TICK_DIV-1. `tick` is high for one cycle when the counter wraps.
- `req[k]` sets `pending[k]`.
  - If `pending[k]` is already 1 and is not being cleared this cycle, the request is dropped and `ovf_cnt` increments (holds at 255).
- Holdoff counters:
  - `hold[k]` decrements on `tick` while nonzero.
  - It is loaded with `min_ivl[k]` on channel k's handshake. The interval is sampled at that instant.
  - If `min_ivl[k]`=0, no holdoff applies.
  - Holdoff counters run regardless of `enable`.
- Channel k is eligible when `pending[k]` is 1, `hold[k]` is 0 and `enable` is 1.
- Round-robin:
  - The search starts at `rr_ptr` and wraps modulo N_CH.
  - On a handshake, `rr_ptr` is set to granted channel + 1 (wrapping).
- FSM states and transitions:
  - IDLE: if any channel is eligible, latch the winner into `m_ch`, assert `m_valid`, go to SEND.
  - SEND: hold `m_valid`, `m_ch` and `m_seq` stable until `m_ready`. On `m_valid`&&`m_ready`:
    - clear `pending[m_ch]` and load its holdoff
    - increment `m_seq` (wraps 0xFFFF→0)
    - pulse `irq`
    - deassert `m_valid`
    - go to IDLE
- Boundary conditions:
  - `req[m_ch]` arriving in the handshake cycle leaves `pending` at 1 and does not count as an overflow.
  - `enable` falling during SEND: `m_valid` is never withdrawn; the transfer completes and no further grants are made.
  - Only one descriptor is outstanding at any time.
  - Reset in any state returns the FSM to IDLE with all state cleared. Any descriptor in flight is abandoned.

## Timing
- Reset values:
  - outputs: `m_valid`=0, `m_ch`=0, `m_seq`=0, `irq`=0, `busy`=0, `ovf_cnt`=0, `pending`=0
  - internal: `hold`=0, `rr_ptr`=0, tick counter=0
- `req[k]` at cycle t: `pending[k]` is visible at t+1. If the FSM is in IDLE and k wins, `m_valid` is high at t+2.
- Handshake at cycle h: `irq`=1 and `m_valid`=0 at h+1. `m_seq` and `pending` are updated at h+1. The FSM is in IDLE at h+1.
- The next earliest `m_valid` is at h+2. Grant spacing is therefore at least 2 cycles.
- `m_ready` held high with all channels eligible gives one grant every 2 cycles.
- Holdoff of n ms: the channel becomes eligible between n-1 and n ms after the handshake (tick phase is not reset on grant).

## Structure
- Package `mqtt_demo_pkg` holds:
  - the FSM state enum `pub_state_t` (IDLE, SEND)
  - the `SEQ_W`=16 and `OVF_W`=8 constants
  - a clog2-based `ch_idx_t` width helper
- Sub-module `mqtt_rr_arbiter` is purely combinational:
  - inputs: `eligible[N_CH]` and `rr_ptr`
  - outputs: `gnt_valid` and `gnt_idx`
- The per-channel holdoff counters are generated inline in the top.

## Test plan
- Bench settings for all scenarios: TICK_DIV=10, N_CH=4, `m_ready`=1, `min_ivl`=0 unless stated.
- Single request: `req[2]` pulse at cycle 5 → `m_valid` at 7 with `m_ch`=2 and `m_seq`=0; `irq` at 8; `pending`=0 at 8.
- Round-robin: all four `req` pulsed together → grants in order 0,1,2,3 at 2-cycle spacing; `m_seq` 0..3.
- Backpressure and enable:
  - `m_ready`=0 for 20 cycles → `m_valid`, `m_ch` and `m_seq` stay stable throughout.
  - Dropping `enable` mid-stall does not withdraw `m_valid`; no grant follows.
- Holdoff: `min_ivl[1]`=3 with repeated `req[1]` → second grant 20–30 cycles after the first handshake, never earlier.
- Overflow: two `req[0]` pulses while `enable`=0 → `ovf_cnt`=1; 300 such pulses → `ovf_cnt`=255.
- Reset mid-SEND: `rst_n`=0 for one cycle → all outputs return to reset values on the next cycle; no `irq`.
